// File: rtl/skid_pkg.sv
// Shared types and occupancy encodings for the skid register slice.
package skid_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

  localparam logic [1:0] CNT_EMPTY = 2'd0;
  localparam logic [1:0] CNT_ONE   = 2'd1;
  localparam logic [1:0] CNT_TWO   = 2'd2;

endpackage

// File: rtl/slice_reg.sv
// Enable register with asynchronous reset to a parameterised value.
module slice_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/skid_reg_slice.sv
// Two-entry skid buffer: full-throughput valid/ready slice whose handshake
// outputs decode registered state only, cutting the combinational ready path.
module skid_reg_slice
  import skid_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [1:0]       count
);

  skid_state_t      state;
  skid_state_t      state_nxt;
  logic             in_fire;
  logic             out_fire;
  logic             main_en;
  logic             skid_en;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  // Handshake outputs: flush is the only live input allowed to touch s_ready.
  assign m_valid  = (state != EMPTY);
  assign s_ready  = (state != TWO) && !flush;
  assign m_data   = main_q;
  assign in_fire  = s_valid && s_ready;
  assign out_fire = m_valid && m_ready;

  always_comb begin
    case (state)
      ONE:     count = CNT_ONE;
      TWO:     count = CNT_TWO;
      default: count = CNT_EMPTY;
    endcase
  end

  always_comb begin
    state_nxt = state;
    main_en   = 1'b0;
    skid_en   = 1'b0;
    main_d    = s_data;
    skid_d    = s_data;
    if (flush) begin
      state_nxt = EMPTY;
      main_en   = 1'b1;
      skid_en   = 1'b1;
      main_d    = RESET_VAL;
      skid_d    = RESET_VAL;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state_nxt = ONE;
            main_en   = 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_en = 1'b1;
          end else if (in_fire) begin
            state_nxt = TWO;
            skid_en   = 1'b1;
          end else if (out_fire) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          // s_ready is low here, so only the drain side can move.
          if (out_fire) begin
            state_nxt = ONE;
            main_en   = 1'b1;
            main_d    = skid_q;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  slice_reg #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_main (
    .clk (clk),
    .rst (rst),
    .en  (main_en),
    .d   (main_d),
    .q   (main_q)
  );

  slice_reg #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_skid (
    .clk (clk),
    .rst (rst),
    .en  (skid_en),
    .d   (skid_d),
    .q   (skid_q)
  );

endmodule

// File: tb/tb_skid_reg_slice.sv
// Directed and random self-checking bench for skid_reg_slice.
`timescale 1ns/100ps
module tb_skid_reg_slice;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [1:0] count;

  int n_cmp  = 0;
  int n_fail = 0;

  skid_reg_slice #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .count   (count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; s_valid = 1'b1; s_data = 8'hEE; m_ready = 1'b0;
    #12;
    n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
    n_cmp++; if (count !== 2'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", count); end
    n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL rst_s_ready: got %b want 1", s_ready); end
    n_cmp++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL rst_m_data: got %h want 00", m_data); end
    s_valid = 1'b0;
    rst = 1'b0;
    step();
    n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_drop: got m_valid %b want 0", m_valid); end
  endtask

  task automatic test_reset_midop();
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 8'hA5; step();
    s_data = 8'h3C; step();
    s_valid = 1'b0;
    n_cmp++; if (count !== 2'd2) begin n_fail++; $display("FAIL midop_fill: got count %0d want 2", count); end
    rst = 1'b1;
    #1;
    n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL midop_m_valid: got %b want 0", m_valid); end
    n_cmp++; if (count !== 2'd0) begin n_fail++; $display("FAIL midop_count: got %0d want 0", count); end
    n_cmp++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL midop_m_data: got %h want 00", m_data); end
    n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL midop_s_ready: got %b want 1", s_ready); end
    rst = 1'b0;
    step();
    n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL midop_after: got m_valid %b want 0", m_valid); end
  endtask

  task automatic test_streaming();
    m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      s_valid = 1'b1; s_data = 8'(i);
      n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL stream_s_ready[%0d]: got %b want 1", i, s_ready); end
      step();
      n_cmp++; if (m_valid !== 1'b1 || m_data !== 8'(i)) begin
        n_fail++; $display("FAIL stream_data[%0d]: got v=%b d=%h want v=1 d=%h", i, m_valid, m_data, 8'(i));
      end
      n_cmp++; if (count !== 2'd1) begin n_fail++; $display("FAIL stream_count[%0d]: got %0d want 1", i, count); end
    end
    s_valid = 1'b0;
    step();
    n_cmp++; if (m_valid !== 1'b0 || count !== 2'd0) begin
      n_fail++; $display("FAIL stream_drain: got v=%b c=%0d want v=0 c=0", m_valid, count);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 8'hA5; step();
    n_cmp++; if (count !== 2'd1 || m_data !== 8'hA5) begin
      n_fail++; $display("FAIL bp_one: got c=%0d d=%h want c=1 d=a5", count, m_data);
    end
    s_data = 8'h3C; step();
    s_valid = 1'b0;
    n_cmp++; if (count !== 2'd2) begin n_fail++; $display("FAIL bp_count2: got %0d want 2", count); end
    n_cmp++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL bp_s_ready: got %b want 0", s_ready); end
    n_cmp++; if (m_data !== 8'hA5) begin n_fail++; $display("FAIL bp_stable0: got %h want a5", m_data); end
    step();
    n_cmp++; if (m_data !== 8'hA5 || count !== 2'd2) begin
      n_fail++; $display("FAIL bp_stable1: got d=%h c=%0d want d=a5 c=2", m_data, count);
    end
    m_ready = 1'b1;
    n_cmp++; if (m_valid !== 1'b1 || m_data !== 8'hA5) begin
      n_fail++; $display("FAIL bp_out0: got v=%b d=%h want v=1 d=a5", m_valid, m_data);
    end
    step();
    n_cmp++; if (m_valid !== 1'b1 || m_data !== 8'h3C || count !== 2'd1) begin
      n_fail++; $display("FAIL bp_out1: got v=%b d=%h c=%0d want v=1 d=3c c=1", m_valid, m_data, count);
    end
    step();
    n_cmp++; if (m_valid !== 1'b0 || count !== 2'd0) begin
      n_fail++; $display("FAIL bp_empty: got v=%b c=%0d want v=0 c=0", m_valid, count);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_flush();
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 8'h12; step();
    s_data = 8'h34; step();
    n_cmp++; if (count !== 2'd2) begin n_fail++; $display("FAIL flush_fill: got %0d want 2", count); end
    flush = 1'b1; s_valid = 1'b1; s_data = 8'h77;
    #1;
    n_cmp++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL flush_s_ready: got %b want 0", s_ready); end
    step();
    flush = 1'b0; s_valid = 1'b0;
    n_cmp++; if (count !== 2'd0 || m_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_empty: got c=%0d v=%b want c=0 v=0", count, m_valid);
    end
    n_cmp++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL flush_m_data: got %h want 00", m_data); end
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no77[%0d]: got v=%b d=%h want v=0", i, m_valid, m_data); end
    end
    m_ready = 1'b0;
  endtask

  task automatic test_in_out_one();
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 8'h11; step();
    s_data = 8'h22; m_ready = 1'b1;
    n_cmp++; if (m_data !== 8'h11 || s_ready !== 1'b1) begin
      n_fail++; $display("FAIL inout_pre: got d=%h r=%b want d=11 r=1", m_data, s_ready);
    end
    step();
    s_valid = 1'b0;
    n_cmp++; if (m_valid !== 1'b1 || m_data !== 8'h22 || count !== 2'd1) begin
      n_fail++; $display("FAIL inout_post: got v=%b d=%h c=%0d want v=1 d=22 c=1", m_valid, m_data, count);
    end
    step();
    n_cmp++; if (count !== 2'd0) begin n_fail++; $display("FAIL inout_drain: got %0d want 0", count); end
    m_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic       stall_prev = 1'b0;
    logic [7:0] data_prev  = 8'h00;
    int         delivered  = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      n_cmp++; if (int'(count) !== q.size() || count > 2'd2) begin
        n_fail++; $display("FAIL rnd_count[%0d]: got %0d want %0d", cyc, count, q.size());
      end
      n_cmp++; if (m_valid !== (q.size() != 0)) begin
        n_fail++; $display("FAIL rnd_valid[%0d]: got %b want %b", cyc, m_valid, q.size() != 0);
      end
      if (stall_prev) begin
        n_cmp++; if (m_valid !== 1'b1 || m_data !== data_prev) begin
          n_fail++; $display("FAIL rnd_stall[%0d]: got v=%b d=%h want v=1 d=%h", cyc, m_valid, m_data, data_prev);
        end
      end
      s_valid = 1'($urandom_range(0, 1));
      m_ready = 1'($urandom_range(0, 1));
      s_data  = 8'($urandom);
      #1;
      if (m_valid && m_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL rnd_order[%0d]: got %h want nothing", cyc, m_data);
        end else begin
          if (m_data !== q[0]) begin
            n_fail++; $display("FAIL rnd_order[%0d]: got %h want %h", cyc, m_data, q[0]);
          end
          void'(q.pop_front());
          delivered++;
        end
      end
      if (s_valid && s_ready) q.push_back(s_data);
      stall_prev = m_valid && !m_ready;
      data_prev  = m_data;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (m_valid && q.size() != 0) begin
        n_cmp++; if (m_data !== q[0]) begin n_fail++; $display("FAIL rnd_drain: got %h want %h", m_data, q[0]); end
        void'(q.pop_front());
        delivered++;
      end
      step();
    end
    n_cmp++; if (q.size() != 0 || m_valid !== 1'b0) begin
      n_fail++; $display("FAIL rnd_loss: got %0d beats left v=%b want 0 v=0", q.size(), m_valid);
    end
    n_cmp++; if (delivered < 1000) begin n_fail++; $display("FAIL rnd_traffic: got %0d delivered want >=1000", delivered); end
    m_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_reset_midop();
    test_streaming();
    test_backpressure();
    test_flush();
    test_in_out_one();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
